seven_seg_scan_driver: RTL

// - Time-multiplexed N-digit seven-segment display driver; generalises the single-digit BCD-to-seven-segment decoder.
// - Decodes each 4-bit code with the same segment table as the single-digit decoder.
// - Adds a scan prescaler and a double-buffered digit register that swaps only at frame boundaries.
// - Adds leading-zero suppression, blanking, anode dead-time and polarity selection.
// - Sits between the core's display/debug register and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_lut.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment table, blank code and the decode helper.
// Segment vectors are {a,b,c,d,e,f,g} with bit6 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes A..E map to the classic 7447-style glyphs; code F is blank.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70,
    7'h7F, 7'h73, 7'h0D, 7'h19, 7'h23, 7'h4B, 7'h0F, 7'h00
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    return SEG_LUT[code];
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational 4-bit code to seven-segment decoder.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_decode(code_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered digits,
// leading-zero suppression, blanking, anode dead-time and pin polarity control.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  en,
  input  logic                                                  bi_n,
  input  logic                                                  lzs,
  input  logic                                                  load,
  input  logic [4*NUM_DIGITS-1:0]                               bcd_in,
  output logic [6:0]                                            seg_o,
  output logic [NUM_DIGITS-1:0]                                 an_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] dp_idx_o,
  output logic                                                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  shadow_valid_q, shadow_valid_d;
  logic [DW-1:0]         display_q, display_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [IW-1:0]         dp_idx_q, dp_idx_d;
  logic                  tick_q, tick_d;

  logic                  slot_wrap;
  logic                  fb;
  logic [3:0]            digit_code;
  logic                  digit_suppress;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic                  zero_above;
  logic [6:0]            lut_seg;
  logic [6:0]            seg_val;

  assign slot_wrap = (cnt_q == CNT_MAX);
  assign fb        = en && slot_wrap && (idx_q == IDX_MAX);

  // Digit select plus the suppression flag, scanning from the most significant digit down.
  always_comb begin
    digit_code     = 4'h0;
    digit_suppress = 1'b0;
    an_onehot      = '0;
    zero_above     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (display_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        digit_code     = display_q[4*k +: 4];
        digit_suppress = lzs && (k != 0) && zero_above;
        an_onehot[k]   = 1'b1;
      end
    end
  end

  seg7_lut u_lut (
    .code_i (digit_code),
    .seg_o  (lut_seg)
  );

  assign seg_val = digit_suppress ? SEG_BLANK : lut_seg;

  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    display_d      = display_q;
    seg_d          = seg_q;
    an_d           = an_q;
    dp_idx_d       = dp_idx_q;
    tick_d         = fb;

    if (en) begin
      cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
      if (slot_wrap) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      seg_d    = (bi_n ? seg_val : SEG_BLANK) ^ SEG_OFF;
      an_d     = ((bi_n && (cnt_q != '0)) ? an_onehot : {NUM_DIGITS{1'b0}}) ^ AN_OFF;
      dp_idx_d = idx_q;
    end

    // A load coinciding with the frame boundary bypasses the shadow so nothing is lost.
    if (load && fb) begin
      shadow_d       = bcd_in;
      display_d      = bcd_in;
      shadow_valid_d = 1'b0;
    end else begin
      if (fb && shadow_valid_q) begin
        display_d      = shadow_q;
        shadow_valid_d = 1'b0;
      end
      if (load) begin
        shadow_d       = bcd_in;
        shadow_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      display_q      <= '0;
      seg_q          <= SEG_OFF;
      an_q           <= AN_OFF;
      dp_idx_q       <= '0;
      tick_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      display_q      <= display_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      dp_idx_q       <= dp_idx_d;
      tick_q         <= tick_d;
    end
  end

  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign dp_idx_o   = dp_idx_q;
  assign frame_tick = tick_q;

endmodule
